branch_predict_ctrl: RTL and testbench
======================================

# branch_predict_ctrl

Branch prediction and misprediction-recovery controller for the pipelined CPU. It predicts conditional branches at IF from a PC-indexed table of 2-bit saturating counters. It resolves each branch at EX from the ALU zero/sign flags and the branch type, then trains the table. On a misprediction it issues a registered one-cycle redirect and flush. It sits between the IF-stage PC mux, the EX-stage ALU flags and the pipeline-register flush inputs.

## Interface
- IDX_W, 4, table index width; table depth 2**IDX_W, indexed by pc[IDX_W+1:2]
- PC_W, 32, program-counter width
- CNT_W, 16, width of the performance counters
- clk_i  in  1  clock, rising edge
- rst_i  in  1  asynchronous, active-low reset
- if_pc_i  in  PC_W  PC of the instruction being fetched
- pred_taken_o  out  1  combinational prediction for if_pc_i: counter MSB
- ex_valid_i  in  1  EX holds a valid, non-squashed instruction
- ex_branch_i  in  1  EX instruction is a conditional branch
- ex_pc_i  in  PC_W  PC of the EX instruction
- branch_type_i  in  2  00 BEQ, 01 BNE, 10 BLT, 11 BLE
- zero_i  in  1  ALU zero flag
- result_31_i  in  1  ALU result bit 31 (sign of rs−rt)
- ex_pred_taken_i  in  1  prediction carried down the pipeline with the branch
- ex_target_i  in  PC_W  branch target address
- ex_pc_plus4_i  in  PC_W  fall-through address
- redirect_o  out  1  registered; PC must load redirect_pc_o
- redirect_pc_o  out  PC_W  registered corrective PC
- flush_o  out  1  registered; squash IF/ID and ID/EX contents
- br_cnt_o  out  CNT_W  resolved-branch count
- miss_cnt_o  out  CNT_W  misprediction count

## Operation
- Condition evaluation:
  - taken = BEQ: zero_i
  - BNE: !zero_i
  - BLT: result_31_i
  - BLE: zero_i | result_31_i
- Resolution event: ex_valid_i & ex_branch_i while the FSM is in RUN.
- On a resolution event:
  - Entry ex_pc_i[IDX_W+1:2] saturates up if taken, otherwise down (00 SNT, 01 WNT, 10 WT, 11 ST).
  - br_cnt_o increments.
- Mispredict: taken != ex_pred_taken_i.
  - miss_cnt_o increments.
  - Next cycle: redirect_o = flush_o = 1.
  - redirect_pc_o = taken ? ex_target_i : ex_pc_plus4_i.
- FSM has two states:
  - RUN → FLUSH on mispredict.
  - FLUSH → RUN unconditionally after one cycle.
  - In FLUSH, all EX inputs are ignored (no update, no count), because the EX instruction is wrong-path.
- Counters saturate at all-ones and never wrap.
- Non-branch or invalid EX instructions never touch the table or counters.

## Timing
- Reset (rst_i low, asynchronous):
  - FSM = RUN.
  - All table entries = 01 (WNT).
  - redirect_o = 0, flush_o = 0, redirect_pc_o = 0.
  - br_cnt_o = 0, miss_cnt_o = 0.
  - pred_taken_o therefore reads 0.
- Reset asserted mid-FLUSH aborts the flush; state returns to RUN immediately.
- Prediction latency is 0: pred_taken_o is a combinational table read.
- Table update, counter increment and redirect/flush all take effect at the clock edge ending the resolution cycle. Latency is 1 cycle.
- redirect_o and flush_o are pulses exactly one cycle wide. Back-to-back redirects are impossible because FLUSH always ignores EX.
- Same-index collision: if if_pc_i and ex_pc_i map to the same entry in one cycle, pred_taken_o returns the pre-update value. The update is visible the following cycle.
- Correctly predicted branches produce no redirect and no flush.

## Structure
- Shared package branch_pkg:
  - branch-type encodings BR_BEQ/BR_BNE/BR_BLT/BR_BLE
  - counter encodings SNT/WNT/WT/ST
  - FSM state type {RUN, FLUSH}
- One sub-module, bht_2bit. It holds the 2**IDX_W × 2-bit counter array with one combinational read port, one synchronous saturating-update port, and async active-low reset to WNT.
- Condition evaluation, FSM, redirect registers and perf counters live in branch_predict_ctrl.

## Test plan
- Reset then idle: after rst_i release, pred_taken_o = 0 for every PC and all outputs are 0; an async reset pulse mid-cycle clears them immediately.
- Training: BEQ at ex_pc_i = 0x40, zero_i = 1, ex_pred_taken_i = 0.
  - Next cycle: redirect_o = flush_o = 1, redirect_pc_o = ex_target_i = 0x80, miss_cnt_o = 1.
  - Repeat after FLUSH with ex_pred_taken_i = 1: no redirect, br_cnt_o = 2.
  - pred_taken_o at if_pc_i = 0x40 is 1 (entry ST).
- Not-taken recovery: entry at ST, BNE with zero_i = 1, ex_pred_taken_i = 1 → redirect_pc_o = ex_pc_plus4_i = 0x44, entry becomes WT.
- Shadow ignore: mispredict at cycle t; at t+1 present a second valid branch in EX → no table change, counters unchanged, flush_o low at t+2.
- Collision: if_pc_i = ex_pc_i = 0x10 with entry WNT, taken resolution → pred_taken_o = 0 that cycle, 1 the next.
- Saturation and types: drive 0x10000 resolutions → br_cnt_o holds 0xFFFF; BLT with result_31_i = 1 and BLE with zero_i = 1 both resolve taken, BLT with both flags 0 resolves not taken.

Source files
------------

// File: rtl/branch_pkg.sv
// Shared encodings and helpers for the branch predictor: branch types,
// 2-bit counter states, controller FSM states.
package branch_pkg;

    typedef enum logic [1:0] {
        BR_BEQ = 2'b00,
        BR_BNE = 2'b01,
        BR_BLT = 2'b10,
        BR_BLE = 2'b11
    } br_type_e;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } ctr_e;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } state_e;

    // Branch outcome from the ALU flags; neg is the sign of rs - rt.
    function automatic logic eval_taken(input br_type_e btype,
                                        input logic     zero,
                                        input logic     neg);
        logic taken;
        taken = 1'b0;
        case (btype)
            BR_BEQ:  taken = zero;
            BR_BNE:  taken = !zero;
            BR_BLT:  taken = neg;
            BR_BLE:  taken = zero | neg;
            default: taken = 1'b0;
        endcase
        return taken;
    endfunction

    // Saturating step of a 2-bit counter toward the observed outcome.
    function automatic ctr_e ctr_update(input ctr_e cur, input logic taken);
        logic [1:0] val;
        val = cur;
        if (taken && cur != ST) begin
            val = val + 2'd1;
        end else if (!taken && cur != SNT) begin
            val = val - 2'd1;
        end
        return ctr_e'(val);
    endfunction

endpackage

// File: rtl/bht_2bit.sv
// Branch history table: 2**IDX_W two-bit saturating counters with one
// combinational read port and one synchronous update port.
module bht_2bit
    import branch_pkg::*;
#(
    parameter int IDX_W = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [IDX_W-1:0] rd_idx_i,
    output logic             rd_taken_o,
    input  logic             upd_en_i,
    input  logic [IDX_W-1:0] upd_idx_i,
    input  logic             upd_taken_i
);

    localparam int DEPTH = 2 ** IDX_W;

    ctr_e ctr_q [DEPTH];

    // Read sees the pre-update value when read and update hit the same entry.
    assign rd_taken_o = ctr_q[rd_idx_i][1];

    // NOTE: the array lives in flops, not RAM, so it can and must be reset to WNT.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                ctr_q[i] <= WNT;
            end
        end else if (upd_en_i) begin
            ctr_q[upd_idx_i] <= ctr_update(ctr_q[upd_idx_i], upd_taken_i);
        end
    end

endmodule

// File: rtl/branch_predict_ctrl.sv
// Branch prediction and misprediction recovery: predicts at IF, resolves at
// EX, trains the history table and issues a one-cycle redirect/flush.
module branch_predict_ctrl
    import branch_pkg::*;
#(
    parameter int IDX_W = 4,
    parameter int PC_W  = 32,
    parameter int CNT_W = 16
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [PC_W-1:0] if_pc_i,
    output logic            pred_taken_o,
    input  logic            ex_valid_i,
    input  logic            ex_branch_i,
    input  logic [PC_W-1:0] ex_pc_i,
    input  logic [1:0]      branch_type_i,
    input  logic            zero_i,
    input  logic            result_31_i,
    input  logic            ex_pred_taken_i,
    input  logic [PC_W-1:0] ex_target_i,
    input  logic [PC_W-1:0] ex_pc_plus4_i,
    output logic            redirect_o,
    output logic [PC_W-1:0] redirect_pc_o,
    output logic            flush_o,
    output logic [CNT_W-1:0] br_cnt_o,
    output logic [CNT_W-1:0] miss_cnt_o
);

    state_e            state_q;
    logic              redirect_q;
    logic              flush_q;
    logic [PC_W-1:0]   redirect_pc_q;
    logic [CNT_W-1:0]  br_cnt_q,   br_cnt_d;
    logic [CNT_W-1:0]  miss_cnt_q, miss_cnt_d;

    logic taken;
    logic resolve;
    logic mispredict;

    // Only the word-index bits of each PC select a table entry.
    logic pc_unused;
    assign pc_unused = ^{if_pc_i[PC_W-1:IDX_W+2], if_pc_i[1:0],
                         ex_pc_i[PC_W-1:IDX_W+2], ex_pc_i[1:0]};

    assign taken      = eval_taken(br_type_e'(branch_type_i), zero_i, result_31_i);
    assign resolve    = ex_valid_i && ex_branch_i && (state_q == RUN);
    assign mispredict = resolve && (taken != ex_pred_taken_i);

    bht_2bit #(
        .IDX_W(IDX_W)
    ) u_bht (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .rd_idx_i    (if_pc_i[IDX_W+1:2]),
        .rd_taken_o  (pred_taken_o),
        .upd_en_i    (resolve),
        .upd_idx_i   (ex_pc_i[IDX_W+1:2]),
        .upd_taken_i (taken)
    );

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        br_cnt_d   = br_cnt_q;
        miss_cnt_d = miss_cnt_q;
        if (resolve && br_cnt_q != '1) begin
            br_cnt_d = br_cnt_q + CNT_W'(1);
        end
        if (mispredict && miss_cnt_q != '1) begin
            miss_cnt_d = miss_cnt_q + CNT_W'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            br_cnt_q   <= '0;
            miss_cnt_q <= '0;
        end else begin
            br_cnt_q   <= br_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    // FLUSH lasts exactly one cycle, so redirect/flush are single-cycle pulses.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q       <= RUN;
            redirect_q    <= 1'b0;
            flush_q       <= 1'b0;
            redirect_pc_q <= '0;
        end else begin
            redirect_q <= 1'b0;
            flush_q    <= 1'b0;
            case (state_q)
                RUN: begin
                    if (mispredict) begin
                        state_q       <= FLUSH;
                        redirect_q    <= 1'b1;
                        flush_q       <= 1'b1;
                        redirect_pc_q <= taken ? ex_target_i : ex_pc_plus4_i;
                    end
                end
                FLUSH:   state_q <= RUN;
                default: state_q <= RUN;
            endcase
        end
    end

    assign redirect_o    = redirect_q;
    assign flush_o       = flush_q;
    assign redirect_pc_o = redirect_pc_q;
    assign br_cnt_o      = br_cnt_q;
    assign miss_cnt_o    = miss_cnt_q;

endmodule

// File: tb/tb_branch_predict_ctrl.sv
// Scoreboard bench for branch_predict_ctrl: a reference model pushes the
// expected post-edge outputs each cycle; they are popped and compared after the edge.
module tb_branch_predict_ctrl;

    logic        clk_i;
    logic        rst_i;
    logic [31:0] if_pc_i;
    logic        pred_taken_o;
    logic        ex_valid_i;
    logic        ex_branch_i;
    logic [31:0] ex_pc_i;
    logic [1:0]  branch_type_i;
    logic        zero_i;
    logic        result_31_i;
    logic        ex_pred_taken_i;
    logic [31:0] ex_target_i;
    logic [31:0] ex_pc_plus4_i;
    logic        redirect_o;
    logic [31:0] redirect_pc_o;
    logic        flush_o;
    logic [15:0] br_cnt_o;
    logic [15:0] miss_cnt_o;

    branch_predict_ctrl #(.IDX_W(4), .PC_W(32), .CNT_W(16)) dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .if_pc_i         (if_pc_i),
        .pred_taken_o    (pred_taken_o),
        .ex_valid_i      (ex_valid_i),
        .ex_branch_i     (ex_branch_i),
        .ex_pc_i         (ex_pc_i),
        .branch_type_i   (branch_type_i),
        .zero_i          (zero_i),
        .result_31_i     (result_31_i),
        .ex_pred_taken_i (ex_pred_taken_i),
        .ex_target_i     (ex_target_i),
        .ex_pc_plus4_i   (ex_pc_plus4_i),
        .redirect_o      (redirect_o),
        .redirect_pc_o   (redirect_pc_o),
        .flush_o         (flush_o),
        .br_cnt_o        (br_cnt_o),
        .miss_cnt_o      (miss_cnt_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    typedef struct {
        logic        redirect;
        logic        flush;
        logic [31:0] rpc;
        logic [15:0] br;
        logic [15:0] miss;
    } exp_t;

    exp_t sb_q[$];

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state.
    logic [1:0]  m_tab [16];
    logic        m_flush_state;
    logic [15:0] m_br;
    logic [15:0] m_miss;
    logic [31:0] m_rpc;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic int idx(input logic [31:0] pc);
        return int'(pc[5:2]);
    endfunction

    function automatic logic model_taken(input logic [1:0] bt, input logic z, input logic n);
        if (bt == 2'b00) return z;
        if (bt == 2'b01) return !z;
        if (bt == 2'b10) return n;
        return z || n;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_tab[i] = 2'b01;
        m_flush_state = 1'b0;
        m_br   = '0;
        m_miss = '0;
        m_rpc  = '0;
    endtask

    task automatic idle_inputs();
        ex_valid_i = 0; ex_branch_i = 0; ex_pc_i = 0; branch_type_i = 0;
        zero_i = 0; result_31_i = 0; ex_pred_taken_i = 0;
        ex_target_i = 0; ex_pc_plus4_i = 0;
    endtask

    // One cycle: drive at posedge+1, check prediction, push expectation,
    // then pop and compare after the next edge.
    task automatic step(input string tag, input logic v, input logic b,
                        input logic [1:0] bt, input logic z, input logic n,
                        input logic p, input logic [31:0] pc,
                        input logic [31:0] tgt, input logic [31:0] ifpc);
        exp_t e;
        logic tk;
        int   ix;
        ex_valid_i = v; ex_branch_i = b; branch_type_i = bt;
        zero_i = z; result_31_i = n; ex_pred_taken_i = p;
        ex_pc_i = pc; ex_target_i = tgt; ex_pc_plus4_i = pc + 32'd4;
        if_pc_i = ifpc;
        #1;
        check({tag, "/pred"}, 32'(pred_taken_o), 32'(m_tab[idx(ifpc)][1]));
        tk = model_taken(bt, z, n);
        e.redirect = 1'b0;
        e.flush    = 1'b0;
        if (v && b && !m_flush_state) begin
            ix = idx(pc);
            if (tk && m_tab[ix] != 2'b11) m_tab[ix] = m_tab[ix] + 2'd1;
            if (!tk && m_tab[ix] != 2'b00) m_tab[ix] = m_tab[ix] - 2'd1;
            if (m_br != 16'hFFFF) m_br = m_br + 16'd1;
            if (tk != p) begin
                if (m_miss != 16'hFFFF) m_miss = m_miss + 16'd1;
                m_rpc = tk ? tgt : pc + 32'd4;
                e.redirect = 1'b1;
                e.flush    = 1'b1;
                m_flush_state = 1'b1;
            end
        end else begin
            m_flush_state = 1'b0;
        end
        e.rpc  = m_rpc;
        e.br   = m_br;
        e.miss = m_miss;
        sb_q.push_back(e);
        @(posedge clk_i);
        #1;
        e = sb_q.pop_front();
        check({tag, "/redirect"}, 32'(redirect_o), 32'(e.redirect));
        check({tag, "/flush"},    32'(flush_o),    32'(e.flush));
        check({tag, "/rpc"},      redirect_pc_o,   e.rpc);
        check({tag, "/br"},       32'(br_cnt_o),   32'(e.br));
        check({tag, "/miss"},     32'(miss_cnt_o), 32'(e.miss));
    endtask

    task automatic idle(input string tag, input logic [31:0] ifpc);
        step(tag, 0, 0, 2'b00, 0, 0, 0, 32'h0, 32'h0, ifpc);
    endtask

    initial begin
        rst_i = 1'b0;
        if_pc_i = 0;
        idle_inputs();
        model_reset();
        repeat (2) @(posedge clk_i);
        #1 rst_i = 1'b1;

        // Reset state: every entry predicts not-taken, outputs clear.
        for (int i = 0; i < 16; i++) begin
            if_pc_i = 32'(i) << 2;
            #1 check("rst/pred", 32'(pred_taken_o), 32'd0);
        end
        check("rst/redirect", 32'(redirect_o), 32'd0);
        check("rst/flush",    32'(flush_o),    32'd0);
        check("rst/rpc",      redirect_pc_o,   32'd0);
        check("rst/br",       32'(br_cnt_o),   32'd0);
        check("rst/miss",     32'(miss_cnt_o), 32'd0);
        @(posedge clk_i); #1;

        // Training on BEQ at 0x40.
        step("train1", 1, 1, 2'b00, 1, 0, 0, 32'h40, 32'h80, 32'h40);
        idle("train_fl", 32'h40);
        step("train2", 1, 1, 2'b00, 1, 0, 1, 32'h40, 32'h80, 32'h40);
        idle("train_st", 32'h40);

        // Not-taken recovery: BNE with zero set.
        step("nt_rec", 1, 1, 2'b01, 1, 0, 1, 32'h40, 32'h80, 32'h40);
        idle("nt_fl", 32'h40);
        idle("nt_wt", 32'h40);

        // Shadow ignore: second branch in FLUSH has no effect.
        step("shad1", 1, 1, 2'b00, 1, 0, 0, 32'h20, 32'h300, 32'h24);
        step("shad2", 1, 1, 2'b00, 1, 0, 0, 32'h24, 32'h400, 32'h24);
        idle("shad3", 32'h24);

        // Collision: same entry read and updated in one cycle.
        step("coll1", 1, 1, 2'b00, 1, 0, 0, 32'h10, 32'h500, 32'h10);
        idle("coll2", 32'h10);

        // Branch types.
        step("blt_t",  1, 1, 2'b10, 0, 1, 1, 32'h04, 32'h600, 32'h04);
        step("ble_t",  1, 1, 2'b11, 1, 0, 1, 32'h08, 32'h700, 32'h08);
        step("blt_nt", 1, 1, 2'b10, 0, 0, 0, 32'h0C, 32'h800, 32'h0C);
        step("blt_nt_miss", 1, 1, 2'b10, 0, 0, 1, 32'h0C, 32'h800, 32'h0C);
        idle("types_fl", 32'h04);
        idle("types_ck", 32'h08);

        // Mid-cycle async reset aborts a flush.
        step("ar_miss", 1, 1, 2'b01, 0, 0, 0, 32'h30, 32'h900, 32'h30);
        #2 rst_i = 1'b0;
        #1;
        model_reset();
        if_pc_i = 32'h40;
        #1;
        check("ar/pred",     32'(pred_taken_o), 32'd0);
        check("ar/redirect", 32'(redirect_o),   32'd0);
        check("ar/flush",    32'(flush_o),      32'd0);
        check("ar/rpc",      redirect_pc_o,     32'd0);
        check("ar/br",       32'(br_cnt_o),     32'd0);
        check("ar/miss",     32'(miss_cnt_o),   32'd0);
        @(posedge clk_i);
        #1 rst_i = 1'b1;
        step("ar_run", 1, 1, 2'b00, 1, 0, 0, 32'h30, 32'hA00, 32'h30);
        idle("ar_fl", 32'h30);

        // Random mix against the model.
        for (int k = 0; k < 60; k++) begin
            step("rand", logic'($urandom_range(0, 3) != 0), logic'($urandom_range(0, 3) != 0),
                 2'($urandom_range(0, 3)), logic'($urandom_range(0, 1)),
                 logic'($urandom_range(0, 1)), logic'($urandom_range(0, 1)),
                 32'h200 + (32'($urandom_range(0, 15)) << 2), 32'h1000 + 32'(k),
                 32'h200 + (32'($urandom_range(0, 15)) << 2));
        end
        idle("pre_sat", 32'h0);

        // Saturation: 0x10000 correctly predicted not-taken resolutions.
        ex_valid_i = 1; ex_branch_i = 1; branch_type_i = 2'b00;
        zero_i = 0; result_31_i = 0; ex_pred_taken_i = 0;
        ex_pc_i = 32'h100; ex_target_i = 32'h0; ex_pc_plus4_i = 32'h104;
        repeat (65536) @(posedge clk_i);
        #1;
        m_br = 16'hFFFF;
        m_tab[idx(32'h100)] = 2'b00;
        check("sat/br",       32'(br_cnt_o),   32'(m_br));
        check("sat/miss",     32'(miss_cnt_o), 32'(m_miss));
        check("sat/redirect", 32'(redirect_o), 32'd0);
        idle_inputs();
        idle("post_sat", 32'h100);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
